cpu_bus_sequencer: RTL

//  Sequences the CPU external bus in machine cycles (M-cycles) of T_PER_M clocks, executing the bus_opcode_t
//  (IDLE/IF/WRITE/READ/IF_CB) issued by the decoder each M-cycle. Arbitrates the single memory port between CPU
//  and the OAM DMA engine, stalls the CPU when it loses, and returns read data / fetched opcodes.

---
 rtl/cpu_bus_sequencer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/cpu_bus_sequencer.sv
// CPU external-bus sequencer: runs T_PER_M-clock M-cycles, arbitrates the memory port between CPU and OAM DMA.
// Optional build macro ARB_RR_EN selects round-robin arbitration instead of strict DMA priority.
module cpu_bus_sequencer #(
  parameter int T_PER_M = 4,
  parameter int AW      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    cpu_op,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  output logic [7:0]    cpu_rdata,
  output logic          cpu_mdone,
  output logic          cpu_stall,
  output logic          ir_load,
  output logic          ir_cb,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [7:0]    dma_wdata,
  output logic [7:0]    dma_rdata,
  output logic          dma_done,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic [7:0]    mem_rdata,
  output logic [2:0]    tcnt
);

  typedef enum logic [2:0] {
    OP_IDLE  = 3'd0,
    OP_IF    = 3'd1,
    OP_WRITE = 3'd2,
    OP_READ  = 3'd3,
    OP_IF_CB = 3'd4
  } bus_opcode_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  localparam logic [2:0] T_LAST = 3'(T_PER_M - 1);
  localparam logic [2:0] T_RCAP = 3'(T_PER_M - 2);

  logic [2:0]    tcnt_q;
  owner_t        owner_q;
  bus_opcode_t   op_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [7:0]    wdata_q;

  bus_opcode_t   op_in;
  logic          dma_win;

  owner_t        cur_owner;
  bus_opcode_t   cur_op;
  logic          cur_we;
  logic [AW-1:0] cur_addr;
  logic [7:0]    cur_wdata;
  logic          bus_rd;
  logic          bus_wr;
  logic          bus_active;

`ifdef ARB_RR_EN
  logic          dma_won_q;
`endif

  // The decoder advances on cpu_mdone, so the next op only appears during tcnt 0; arbitrate live then.
  always_comb begin
    op_in   = (cpu_op > 3'd4) ? OP_IDLE : bus_opcode_t'(cpu_op);
    dma_win = dma_req;
`ifdef ARB_RR_EN
    if (dma_won_q && (op_in != OP_IDLE)) dma_win = 1'b0;
`endif
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cur_owner = owner_q;
    cur_op    = op_q;
    cur_we    = we_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    if (tcnt_q == 3'd0) begin
      cur_owner = dma_win ? OWN_DMA : OWN_CPU;
      cur_op    = op_in;
      cur_we    = dma_we;
      cur_addr  = dma_win ? dma_addr : cpu_addr;
      cur_wdata = dma_win ? dma_wdata : cpu_wdata;
    end
  end

  always_comb begin
    if (cur_owner == OWN_DMA) begin
      bus_rd     = !cur_we;
      bus_wr     = cur_we;
      bus_active = 1'b1;
    end else begin
      bus_rd     = (cur_op == OP_IF) || (cur_op == OP_READ) || (cur_op == OP_IF_CB);
      bus_wr     = (cur_op == OP_WRITE);
      bus_active = (cur_op != OP_IDLE);
    end
  end

  // Outputs are held at 0 while reset is asserted, even though live inputs feed the tcnt 0 path.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    cpu_stall = 1'b0;
    cpu_mdone = 1'b0;
    dma_done  = 1'b0;
    ir_load   = 1'b0;
    ir_cb     = 1'b0;
    if (rst_n) begin
      if (bus_active) mem_addr = cur_addr;
      if (bus_wr) mem_wdata = cur_wdata;
      mem_rd    = bus_rd && (tcnt_q <= T_RCAP);
      mem_wr    = bus_wr && (tcnt_q != 3'd0) && (tcnt_q <= T_RCAP);
      cpu_stall = (cur_owner == OWN_DMA) && (cur_op != OP_IDLE);
      if (tcnt_q == T_LAST) begin
        dma_done  = (cur_owner == OWN_DMA);
        cpu_mdone = (cur_owner == OWN_CPU) || (cur_op == OP_IDLE);
        ir_load   = cpu_mdone && ((cur_op == OP_IF) || (cur_op == OP_IF_CB));
        ir_cb     = ir_load && (cur_op == OP_IF_CB);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tcnt_q    <= 3'd0;
      owner_q   <= OWN_CPU;
      op_q      <= OP_IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
`ifdef ARB_RR_EN
      dma_won_q <= 1'b0;
`endif
    end else begin
      tcnt_q <= (tcnt_q == T_LAST) ? 3'd0 : tcnt_q + 3'd1;
      if (tcnt_q == 3'd0) begin
        owner_q <= cur_owner;
        op_q    <= cur_op;
        we_q    <= cur_we;
        addr_q  <= cur_addr;
        wdata_q <= cur_wdata;
`ifdef ARB_RR_EN
        dma_won_q <= dma_win;
`endif
      end
      if ((tcnt_q == T_RCAP) && bus_rd) begin
        if (cur_owner == OWN_DMA) dma_rdata <= mem_rdata;
        else                      cpu_rdata <= mem_rdata;
      end
    end
  end

  assign tcnt = tcnt_q;

endmodule
